// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared memory map, size/state encodings and access checks.
// Optional alignment faulting is enabled by defining MEM_ALIGN_CHECK_EN.
package mem_access_unit_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   localparam logic [ADDR_W-1:0] MEMORY_SIZE_LO = 32'h0000_1000;
   localparam logic [ADDR_W-1:0] MEMORY_SIZE_HI = 32'h0000_1100;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
   localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
   localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
   localparam logic [1:0] MEM_SIZE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_RESP = 2'b11
   } state_e;

   // End address is computed one bit wider so accesses near 2^32 cannot wrap into range.
   function automatic logic access_fault(input logic [ADDR_W-1:0] addr, input logic [1:0] size);
      logic [ADDR_W:0] end_addr;
      logic            bad;
      end_addr = {1'b0, addr} + ((size == MEM_SIZE_BYTE) ? 33'd1 :
                                 (size == MEM_SIZE_HALF) ? 33'd2 : 33'd4);
      bad = (size == MEM_SIZE_RSVD) || (addr < MEMORY_SIZE_LO) ||
            (end_addr > {1'b0, MEMORY_SIZE_HI});
`ifdef MEM_ALIGN_CHECK_EN
      if ((size == MEM_SIZE_HALF) && addr[0]) bad = 1'b1;
      if ((size == MEM_SIZE_WORD) && (addr[1:0] != 2'b00)) bad = 1'b1;
`else
`endif
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - pipeline request/response and MEMORY data-port bundle.
interface mem_access_unit_if;
   import mem_access_unit_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_fault;
   logic              data_sig_mem_write;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_write_data;
   logic [DATA_W-1:0] data_read_data;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, data_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_fault,
             data_sig_mem_write, data_addr, data_write_data
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, data_read_data,
      output req_ready, resp_valid, resp_rdata, resp_fault,
             data_sig_mem_write, data_addr, data_write_data
   );

endinterface

// File: rtl/mem_access_unit_byte_lane_merge.sv
// rtl/mem_access_unit_byte_lane_merge.sv - little-endian lane insert for stores and
// lane extract/extend for loads; half and word lanes ignore the low address bits.
module byte_lane_merge
   import mem_access_unit_pkg::*;
(
   input  logic [DATA_W-1:0] old_word_i,
   input  logic [DATA_W-1:0] store_data_i,
   input  logic [1:0]        size_i,
   input  logic [1:0]        lane_i,
   input  logic              unsigned_i,
   output logic [DATA_W-1:0] merged_o,
   output logic [DATA_W-1:0] load_val_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      merged_o   = old_word_i;
      load_val_o = old_word_i;
      byte_v     = old_word_i[{lane_i, 3'b000} +: 8];
      half_v     = lane_i[1] ? old_word_i[31:16] : old_word_i[15:0];
      case (size_i)
         MEM_SIZE_BYTE: begin
            merged_o[{lane_i, 3'b000} +: 8] = store_data_i[7:0];
            load_val_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
         end
         MEM_SIZE_HALF: begin
            if (lane_i[1]) merged_o[31:16] = store_data_i[15:0];
            else           merged_o[15:0]  = store_data_i[15:0];
            load_val_o = {{16{~unsigned_i & half_v[15]}}, half_v};
         end
         default: begin
            merged_o   = store_data_i;
            load_val_o = old_word_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit issuing word accesses to MEMORY,
// with read-modify-write for sub-word stores.
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   mem_access_unit_if.slave bus
);

   state_e            state_q, state_d;
   logic              write_q, write_d;
   logic              unsigned_q, unsigned_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              fault_q, fault_d;

   logic [DATA_W-1:0] old_word;
   logic [DATA_W-1:0] merged;
   logic [DATA_W-1:0] load_val;
   logic              busy;

   // Loads extract straight from the live read word; RMW writes merge into the captured one.
   assign old_word = (state_q == ST_RD) ? bus.data_read_data : word_q;

   byte_lane_merge u_merge (
      .old_word_i   (old_word),
      .store_data_i (wdata_q),
      .size_i       (size_q),
      .lane_i       (addr_q[1:0]),
      .unsigned_i   (unsigned_q),
      .merged_o     (merged),
      .load_val_o   (load_val)
   );

   assign busy                   = (state_q == ST_RD) || (state_q == ST_WR);
   assign bus.req_ready          = (state_q == ST_IDLE);
   assign bus.resp_valid         = (state_q == ST_RESP);
   assign bus.resp_rdata         = rdata_q;
   assign bus.resp_fault         = fault_q;
   assign bus.data_sig_mem_write = (state_q == ST_WR);
   assign bus.data_addr          = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign bus.data_write_data    = busy ? ((size_q == MEM_SIZE_WORD) ? wdata_q : merged) : '0;

   always_comb begin
      state_d    = state_q;
      write_d    = write_q;
      unsigned_d = unsigned_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      word_d     = word_q;
      rdata_d    = rdata_q;
      fault_d    = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               write_d    = bus.req_write;
               unsigned_d = bus.req_unsigned;
               size_d     = bus.req_size;
               addr_d     = bus.req_addr;
               wdata_d    = bus.req_wdata;
               if (access_fault(bus.req_addr, bus.req_size)) begin
                  fault_d = 1'b1;
                  rdata_d = '0;
                  state_d = ST_RESP;
               end else if (bus.req_write && (bus.req_size == MEM_SIZE_WORD)) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            word_d = bus.data_read_data;
            if (write_q) begin
               state_d = ST_WR;
            end else begin
               rdata_d = load_val;
               fault_d = 1'b0;
               state_d = ST_RESP;
            end
         end
         ST_WR: begin
            rdata_d = '0;
            fault_d = 1'b0;
            state_d = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         write_q    <= 1'b0;
         unsigned_q <= 1'b0;
         size_q     <= MEM_SIZE_BYTE;
         addr_q     <= '0;
         wdata_q    <= '0;
         word_q     <= '0;
         rdata_q    <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         unsigned_q <= unsigned_d;
         size_q     <= size_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         word_q     <= word_d;
         rdata_q    <= rdata_d;
         fault_q    <= fault_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized and directed checks of mem_access_unit against a
// byte-array reference memory model.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   localparam logic [31:0] A = MEMORY_SIZE_LO + 32'h40;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_access_unit_if bus();

   mem_access_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:63];
   logic [7:0]  ref_b [0:255];
   logic        pre_en = 1'b0;
   logic [5:0]  pre_idx = '0;
   logic [31:0] pre_data = '0;
   logic        in_rng;
   logic [5:0]  widx;

   assign in_rng = (bus.data_addr >= MEMORY_SIZE_LO) && (bus.data_addr < MEMORY_SIZE_HI);
   assign widx   = 6'((bus.data_addr - MEMORY_SIZE_LO) >> 2);
   assign bus.data_read_data = in_rng ? mem[widx] : 32'h0;

   always @(posedge clk) begin
      if (bus.data_sig_mem_write && in_rng) mem[widx] <= bus.data_write_data;
      else if (pre_en)                      mem[pre_idx] <= pre_data;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      int o;
      o = int'((a - MEMORY_SIZE_LO) & 32'hfc);
      return {ref_b[o+3], ref_b[o+2], ref_b[o+1], ref_b[o]};
   endfunction

   task automatic preload(input logic [31:0] a, input logic [31:0] w);
      int o;
      o = int'((a - MEMORY_SIZE_LO) & 32'hfc);
      for (int i = 0; i < 4; i++) ref_b[o+i] = 8'(w >> (8*i));
      @(negedge clk);
      pre_en   = 1'b1;
      pre_idx  = 6'(o >> 2);
      pre_data = w;
      @(posedge clk);
      #1 pre_en = 1'b0;
   endtask

   task automatic do_op(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] got_rdata);
      int          nb, lat, n, nwr, off;
      logic        flt;
      logic [31:0] ea, wa, v, wa_got, wd_got;
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      flt = (sz == 2'd3) || (addr < MEMORY_SIZE_LO) ||
            (64'(addr) + 64'(nb) > 64'(MEMORY_SIZE_HI)) ||
            (ALIGN_EN && (((sz == 2'd1) && addr[0]) || ((sz == 2'd2) && (addr[1:0] != 2'b00))));
      ea  = (sz == 2'd1) ? (addr & ~32'h1) : (sz == 2'd2) ? (addr & ~32'h3) : addr;
      wa  = addr & ~32'h3;
      lat = flt ? 1 : (wr && (sz != 2'd2)) ? 3 : 2;
      v   = 32'h0;
      if (!flt) begin
         off = int'(ea - MEMORY_SIZE_LO);
         if (wr) begin
            for (int i = 0; i < nb; i++) ref_b[off+i] = 8'(wd >> (8*i));
         end else begin
            for (int i = 0; i < nb; i++) v = v | (32'(ref_b[off+i]) << (8*i));
            if (!uns && (sz == 2'd0) && v[7])  v = v | 32'hffffff00;
            if (!uns && (sz == 2'd1) && v[15]) v = v | 32'hffff0000;
         end
      end

      @(negedge clk);
      check("idle_ready", {31'b0, bus.req_ready}, 32'h1);
      check("idle_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
      bus.req_valid    = 1'b1;
      bus.req_write    = wr;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wd;
      @(posedge clk);
      #1;
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'($urandom);
      bus.req_size     = 2'($urandom);
      bus.req_addr     = $urandom;
      bus.req_wdata    = $urandom;

      n = 0;
      nwr = 0;
      wa_got = '0;
      wd_got = '0;
      do begin
         @(negedge clk);
         n++;
         if (bus.data_sig_mem_write) begin
            nwr++;
            wa_got = bus.data_addr;
            wd_got = bus.data_write_data;
         end
      end while (!bus.resp_valid && n < 8);

      got_rdata = bus.resp_rdata;
      check("latency", 32'(n), 32'(lat));
      check("fault", {31'b0, bus.resp_fault}, {31'b0, flt});
      check("rdata", bus.resp_rdata, (flt || wr) ? 32'h0 : v);
      check("write_count", 32'(nwr), (wr && !flt) ? 32'h1 : 32'h0);
      if (wr && !flt) begin
         check("write_addr", wa_got, wa);
         check("write_data", wd_got, ref_word(wa));
         check("mem_word", mem[6'((wa - MEMORY_SIZE_LO) >> 2)], ref_word(wa));
      end
   endtask

   logic [31:0] r;
   logic [31:0] ra;
   int          sel;

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      #1;
      check("rst_ready", {31'b0, bus.req_ready}, 32'h1);
      check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
      check("rst_rdata", bus.resp_rdata, 32'h0);
      check("rst_fault", {31'b0, bus.resp_fault}, 32'h0);
      check("rst_wr", {31'b0, bus.data_sig_mem_write}, 32'h0);
      check("rst_addr", bus.data_addr, 32'h0);
      check("rst_wdata", bus.data_write_data, 32'h0);
      for (int i = 0; i < 64; i++) preload(MEMORY_SIZE_LO + 32'(4*i), $urandom);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(1'b1, 2'd2, 1'b0, MEMORY_SIZE_HI - 4, 32'hdeadbeef, r);
      check("plan_sw_mem", mem[63], 32'hdeadbeef);

      preload(A, 32'h6c6c6568);
      do_op(1'b0, 2'd0, 1'b0, A + 1, 32'h0, r);
      check("plan_lb", r, 32'h00000065);
      do_op(1'b0, 2'd0, 1'b1, A + 3, 32'h0, r);
      check("plan_lbu", r, 32'h0000006c);
      preload(A, 32'h8000ff80);
      do_op(1'b0, 2'd0, 1'b0, A, 32'h0, r);
      check("plan_lb_neg", r, 32'hffffff80);
      do_op(1'b0, 2'd1, 1'b0, A + 2, 32'h0, r);
      check("plan_lh_neg", r, 32'hffff8000);

      preload(A, 32'h12345678);
      do_op(1'b1, 2'd0, 1'b0, A + 2, 32'h000000ab, r);
      check("plan_sb_mem", mem[6'((A - MEMORY_SIZE_LO) >> 2)], 32'h12ab5678);
      do_op(1'b1, 2'd1, 1'b0, A, 32'h0000beef, r);
      check("plan_sh_mem", mem[6'((A - MEMORY_SIZE_LO) >> 2)], 32'h12abbeef);

      do_op(1'b0, 2'd2, 1'b0, MEMORY_SIZE_HI, 32'h0, r);
      do_op(1'b0, 2'd2, 1'b0, MEMORY_SIZE_LO - 4, 32'h0, r);
      do_op(1'b0, 2'd3, 1'b0, A, 32'h0, r);
      do_op(1'b0, 2'd2, 1'b0, A + 2, 32'h0, r);

      for (int k = 0; k < 300; k++) begin
         sel = int'($urandom_range(0, 19));
         if (sel == 0)      ra = MEMORY_SIZE_LO - $urandom_range(1, 8);
         else if (sel == 1) ra = MEMORY_SIZE_HI - $urandom_range(0, 4);
         else               ra = MEMORY_SIZE_LO + $urandom_range(0, 255);
         do_op(1'($urandom), ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
               1'($urandom), ra, $urandom, r);
      end

      preload(A, 32'h12345678);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_size  = 2'd0;
      bus.req_addr  = A + 2;
      bus.req_wdata = 32'h000000ab;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      sel = 0;
      for (int i = 0; i < 6 && sel == 0; i++) begin
         @(negedge clk);
         if (bus.data_sig_mem_write) sel = 1;
      end
      check("rst_mid_saw_wr", 32'(sel), 32'h1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_wr_drop", {31'b0, bus.data_sig_mem_write}, 32'h0);
      check("rst_mid_addr", bus.data_addr, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_ready", {31'b0, bus.req_ready}, 32'h1);
      check("rst_mid_mem", mem[6'((A - MEMORY_SIZE_LO) >> 2)], 32'h12345678);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
